fetch_stage: RTL and testbench

- IF stage and IF/ID pipeline register of the 5-stage MIPS pipeline.
- Holds the PC and drives the instruction-memory address.
- Captures the fetched word and its PC into IF/ID, and presents opcode/func to the ID-stage control decoder.
- Consumes the decoder's npcOp plus isRsRtEq, branch operands and the hazard-unit stall to select the next PC. Squashes the wrong-path fetch on redirect.

---
 rtl/fetch_stage_pkg.sv | 38 +++
 rtl/fetch_stage_npc_unit.sv | 47 ++++
 rtl/fetch_stage.sv | 74 +++++++
 tb/tb_fetch_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared encodings, reset constants, IF/ID record and target helpers for the fetch stage.
// Pure definitions: no logic, no latency, no flow control.
package fetch_stage_pkg;

  localparam int NPC_OP_LENGTH = 2;

  localparam logic [NPC_OP_LENGTH-1:0] NPC_PC4 = 2'b00;
  localparam logic [NPC_OP_LENGTH-1:0] NPC_BEQ = 2'b01;
  localparam logic [NPC_OP_LENGTH-1:0] NPC_J   = 2'b10;
  localparam logic [NPC_OP_LENGTH-1:0] NPC_JR  = 2'b11;

  localparam logic [31:0] RESET_PC_VAL = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        valid;
  } ifId_t;

  // imm16 is a word offset relative to the instruction after the branch.
  function automatic logic [31:0] branchTarget(input logic [31:0] pcPlus4,
                                               input logic [15:0] imm);
    return pcPlus4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  function automatic logic [31:0] jumpTarget(input logic [31:0] pcPlus4,
                                             input logic [25:0] instrIndex);
    return {pcPlus4[31:28], instrIndex, 2'b00};
  endfunction

  // Misaligned register targets are forced onto a word boundary.
  function automatic logic [31:0] jrTarget(input logic [31:0] rsData);
    return {rsData[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_npc_unit.sv
// Next-PC select from the ID-stage instruction; purely combinational, zero latency.
// No flow control: the stall gating is applied by the PC register owner.
module npc_unit
  import fetch_stage_pkg::*;
(
  input  logic [31:0]              pc,
  input  logic [31:0]              pcPlus4D,
  input  logic [31:0]              instrD,
  input  logic [31:0]              rsDataD,
  input  logic [NPC_OP_LENGTH-1:0] npcOp,
  input  logic                     isRsRtEq,
  input  logic                     validD,
  output logic [31:0]              npc,
  output logic                     redirect
);

  logic [31:0] target;
  logic        taken;
  logic        unusedBits;

  assign unusedBits = ^{instrD[31:26], rsDataD[1:0]};

  always_comb begin
    target = pc + 32'd4;
    taken  = 1'b0;
    case (npcOp)
      NPC_PC4: taken = 1'b0;
      NPC_BEQ: begin
        target = branchTarget(pcPlus4D, instrD[15:0]);
        taken  = isRsRtEq;
      end
      NPC_J: begin
        target = jumpTarget(pcPlus4D, instrD[25:0]);
        taken  = 1'b1;
      end
      NPC_JR: begin
        target = jrTarget(rsDataD);
        taken  = 1'b1;
      end
      default: taken = 1'b0;
    endcase
    // A bubble carries no instruction, so its decode must never steer the PC.
    redirect = validD && taken;
    npc      = redirect ? target : pc + 32'd4;
  end

endmodule

// File: rtl/fetch_stage.sv
// PC register plus IF/ID pipeline register; fetched word lands in IF/ID one cycle after imemAddr.
// stall freezes PC and IF/ID (flush still bubbles IF/ID); a taken redirect costs one bubble.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_VAL,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [NPC_OP_LENGTH-1:0] npcOp,
  input  logic                     isRsRtEq,
  input  logic [31:0]              rsDataD,
  output logic [31:0]              imemAddr,
  input  logic [31:0]              imemData,
  output logic [31:0]              instrD,
  output logic [31:0]              pcD,
  output logic [31:0]              pcPlus4D,
  output logic                     validD,
  output logic [5:0]               opcodeD,
  output logic [5:0]               funcD,
  output logic                     redirect
);

  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] npc;
  ifId_t       ifId;
  ifId_t       bubble;

  assign pcPlus4 = pc + 32'd4;
  assign bubble  = '{instr: NOP_INSTR, pc: 32'd0, pcPlus4: 32'd0, valid: 1'b0};

  npc_unit u_npcUnit (
    .pc       (pc),
    .pcPlus4D (ifId.pcPlus4),
    .instrD   (ifId.instr),
    .rsDataD  (rsDataD),
    .npcOp    (npcOp),
    .isRsRtEq (isRsRtEq),
    .validD   (ifId.valid),
    .npc      (npc),
    .redirect (redirect)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc   <= RESET_PC;
      ifId <= bubble;
    end else if (stall) begin
      // The ID instruction is itself held, so its redirect waits; only a squash gets through.
      if (flush) begin
        ifId <= bubble;
      end
    end else if (redirect || flush) begin
      pc   <= npc;
      ifId <= bubble;
    end else begin
      pc   <= pcPlus4;
      ifId <= '{instr: imemData, pc: pc, pcPlus4: pcPlus4, valid: 1'b1};
    end
  end

  assign imemAddr = pc;
  assign instrD   = ifId.instr;
  assign pcD      = ifId.pc;
  assign pcPlus4D = ifId.pcPlus4;
  assign validD   = ifId.valid;
  assign opcodeD  = ifId.instr[31:26];
  assign funcD    = ifId.instr[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: per-cycle stimulus rows carry the expected IF/ID and PC state.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [1:0]  npcOp;
  logic        isRsRtEq;
  logic [31:0] rsDataD;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pcPlus4D;
  logic        validD;
  logic [5:0]  opcodeD;
  logic [5:0]  funcD;
  logic        redirect;
  logic        forceJ;

  int passCnt = 0;
  int totalCnt = 0;

  localparam logic [31:0] BEQ_M2 = 32'h1000_FFFE;
  localparam logic [31:0] J_3040 = 32'h0800_0C10;
  localparam logic [31:0] JR_RA  = 32'h03E0_0008;

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        eq;
    logic        fj;
    logic [31:0] rsData;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic        redir;
  } row_t;

  row_t sbQ[$];
  logic [31:0] mem [64];

  fetch_stage dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .npcOp    (npcOp),
    .isRsRtEq (isRsRtEq),
    .rsDataD  (rsDataD),
    .imemAddr (imemAddr),
    .imemData (imemData),
    .instrD   (instrD),
    .pcD      (pcD),
    .pcPlus4D (pcPlus4D),
    .validD   (validD),
    .opcodeD  (opcodeD),
    .funcD    (funcD),
    .redirect (redirect)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction ROM: word = addr ^ A5A5_0000 unless overridden in the 0x30xx window.
  assign imemData = (imemAddr[31:8] == 24'h000030) ? mem[imemAddr[7:2]]
                                                   : (imemAddr ^ 32'hA5A5_0000);

  // Minimal ID control decode driving npcOp from the IF/ID instruction.
  always_comb begin
    npcOp = 2'b00;
    if (opcodeD == 6'h04) npcOp = 2'b01;
    else if (opcodeD == 6'h02) npcOp = 2'b10;
    else if (opcodeD == 6'h00 && funcD == 6'h08) npcOp = 2'b11;
    if (forceJ) npcOp = 2'b10;
  end

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic initMem();
    for (int i = 0; i < 64; i++) mem[i] = w(32'h0000_3000 + 32'(i * 4));
  endtask

  task automatic push(input logic rs, input logic st, input logic fl, input logic eq,
                      input logic fj, input logic [31:0] rsd, input logic [31:0] addr,
                      input logic v, input logic [31:0] ins, input logic rd);
    row_t r;
    r = '{rst: rs, stall: st, flush: fl, eq: eq, fj: fj, rsData: rsd,
          addr: addr, valid: v, instr: ins, redir: rd};
    sbQ.push_back(r);
  endtask

  task automatic drive(input row_t r);
    rst      = r.rst;
    stall    = r.stall;
    flush    = r.flush;
    isRsRtEq = r.eq;
    forceJ   = r.fj;
    rsDataD  = r.rsData;
  endtask

  task automatic doReset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; isRsRtEq = 1'b0; forceJ = 1'b0; rsDataD = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] w300c;
    initMem();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; isRsRtEq = 1'b0; forceJ = 1'b0; rsDataD = '0;
    @(negedge clk);
    #1;
    totalCnt++;
    if (imemAddr !== 32'h3000) $display("FAIL reset_pc got %h want 00003000", imemAddr);
    else passCnt++;
    totalCnt++;
    if (validD !== 1'b0) $display("FAIL reset_valid got %b want 0", validD);
    else passCnt++;
    totalCnt++;
    if (instrD !== 32'h0) $display("FAIL reset_instr got %h want 00000000", instrD);
    else passCnt++;
    totalCnt++;
    if ({pcD, pcPlus4D} !== 64'h0) $display("FAIL reset_pcD got %h/%h want 0/0", pcD, pcPlus4D);
    else passCnt++;
    @(negedge clk);
    rst = 1'b0;
    push(0,0,0,0,0,0, 32'h3000, 0, 32'h0,        0);
    push(0,0,0,0,0,0, 32'h3004, 1, w(32'h3000),  0);
    push(0,0,0,0,0,0, 32'h3008, 1, w(32'h3004),  0);
    push(0,0,0,0,0,0, 32'h300C, 1, w(32'h3008),  0);
    for (int k = 0; sbQ.size() != 0; k++) begin
      row_t r = sbQ.pop_front();
      drive(r); #1;
      totalCnt++;
      if ({imemAddr, validD, instrD, redirect} !== {r.addr, r.valid, r.instr, r.redir})
        $display("FAIL free_run row %0d got addr=%h v=%b instr=%h rd=%b want addr=%h v=%b instr=%h rd=%b",
                 k, imemAddr, validD, instrD, redirect, r.addr, r.valid, r.instr, r.redir);
      else passCnt++;
      @(negedge clk);
    end
    #1;
    w300c = w(32'h300C);
    totalCnt++;
    if ({pcD, pcPlus4D} !== {32'h300C, 32'h3010})
      $display("FAIL ifid_pc got %h/%h want 0000300c/00003010", pcD, pcPlus4D);
    else passCnt++;
    totalCnt++;
    if ({opcodeD, funcD} !== {w300c[31:26], w300c[5:0]})
      $display("FAIL op_func got %h/%h want %h/%h", opcodeD, funcD, w300c[31:26], w300c[5:0]);
    else passCnt++;
    @(negedge clk);
  endtask

  task automatic test_beq();
    initMem();
    mem[2] = BEQ_M2;
    doReset();
    push(0,0,0,0,0,0, 32'h3000, 0, 32'h0,       0);
    push(0,0,0,0,0,0, 32'h3004, 1, w(32'h3000), 0);
    push(0,0,0,0,0,0, 32'h3008, 1, w(32'h3004), 0);
    push(0,0,0,1,0,0, 32'h300C, 1, BEQ_M2,      1);
    push(0,0,0,0,0,0, 32'h3004, 0, 32'h0,       0);
    push(0,0,0,0,0,0, 32'h3008, 1, w(32'h3004), 0);
    push(0,0,0,0,0,0, 32'h300C, 1, BEQ_M2,      0);
    push(0,0,0,0,0,0, 32'h3010, 1, w(32'h300C), 0);
    for (int k = 0; sbQ.size() != 0; k++) begin
      row_t r = sbQ.pop_front();
      drive(r); #1;
      totalCnt++;
      if ({imemAddr, validD, instrD, redirect} !== {r.addr, r.valid, r.instr, r.redir})
        $display("FAIL beq row %0d got addr=%h v=%b instr=%h rd=%b want addr=%h v=%b instr=%h rd=%b",
                 k, imemAddr, validD, instrD, redirect, r.addr, r.valid, r.instr, r.redir);
      else passCnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_jump();
    initMem();
    mem[4] = J_3040;
    doReset();
    push(0,0,0,0,0,0, 32'h3000, 0, 32'h0,       0);
    push(0,0,0,0,0,0, 32'h3004, 1, w(32'h3000), 0);
    push(0,0,0,0,0,0, 32'h3008, 1, w(32'h3004), 0);
    push(0,0,0,0,0,0, 32'h300C, 1, w(32'h3008), 0);
    push(0,0,0,0,0,0, 32'h3010, 1, w(32'h300C), 0);
    push(0,0,0,0,0,0, 32'h3014, 1, J_3040,      1);
    push(0,0,0,0,0,0, 32'h3040, 0, 32'h0,       0);
    push(0,0,0,0,0,0, 32'h3044, 1, w(32'h3040), 0);
    for (int k = 0; sbQ.size() != 0; k++) begin
      row_t r = sbQ.pop_front();
      drive(r); #1;
      totalCnt++;
      if ({imemAddr, validD, instrD, redirect} !== {r.addr, r.valid, r.instr, r.redir})
        $display("FAIL jump row %0d got addr=%h v=%b instr=%h rd=%b want addr=%h v=%b instr=%h rd=%b",
                 k, imemAddr, validD, instrD, redirect, r.addr, r.valid, r.instr, r.redir);
      else passCnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_jr();
    initMem();
    mem[1] = JR_RA;
    doReset();
    push(0,0,0,0,0,0,            32'h3000, 0, 32'h0,       0);
    push(0,0,0,0,0,0,            32'h3004, 1, w(32'h3000), 0);
    push(0,0,0,0,0,32'h00004007, 32'h3008, 1, JR_RA,       1);
    push(0,0,0,0,0,0,            32'h4004, 0, 32'h0,       0);
    push(0,0,0,0,0,0,            32'h4008, 1, w(32'h4004), 0);
    for (int k = 0; sbQ.size() != 0; k++) begin
      row_t r = sbQ.pop_front();
      drive(r); #1;
      totalCnt++;
      if ({imemAddr, validD, instrD, redirect} !== {r.addr, r.valid, r.instr, r.redir})
        $display("FAIL jr row %0d got addr=%h v=%b instr=%h rd=%b want addr=%h v=%b instr=%h rd=%b",
                 k, imemAddr, validD, instrD, redirect, r.addr, r.valid, r.instr, r.redir);
      else passCnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    initMem();
    mem[1] = BEQ_M2;
    doReset();
    push(0,0,0,0,0,0, 32'h3000, 0, 32'h0,       0);
    push(0,0,0,0,0,0, 32'h3004, 1, w(32'h3000), 0);
    push(0,1,0,1,0,0, 32'h3008, 1, BEQ_M2,      1);
    push(0,1,0,1,0,0, 32'h3008, 1, BEQ_M2,      1);
    push(0,1,0,1,0,0, 32'h3008, 1, BEQ_M2,      1);
    push(0,0,0,1,0,0, 32'h3008, 1, BEQ_M2,      1);
    push(0,0,0,0,0,0, 32'h3000, 0, 32'h0,       0);
    push(0,0,0,0,0,0, 32'h3004, 1, w(32'h3000), 0);
    for (int k = 0; sbQ.size() != 0; k++) begin
      row_t r = sbQ.pop_front();
      drive(r); #1;
      totalCnt++;
      if ({imemAddr, validD, instrD, redirect} !== {r.addr, r.valid, r.instr, r.redir})
        $display("FAIL stall row %0d got addr=%h v=%b instr=%h rd=%b want addr=%h v=%b instr=%h rd=%b",
                 k, imemAddr, validD, instrD, redirect, r.addr, r.valid, r.instr, r.redir);
      else passCnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_rst_pending();
    initMem();
    mem[1] = BEQ_M2;
    doReset();
    push(0,0,0,0,0,0, 32'h3000, 0, 32'h0,       0);
    push(0,0,0,0,0,0, 32'h3004, 1, w(32'h3000), 0);
    push(1,1,0,1,0,0, 32'h3008, 1, BEQ_M2,      1);
    push(0,0,0,0,0,0, 32'h3000, 0, 32'h0,       0);
    push(0,0,0,0,0,0, 32'h3004, 1, w(32'h3000), 0);
    for (int k = 0; sbQ.size() != 0; k++) begin
      row_t r = sbQ.pop_front();
      drive(r); #1;
      totalCnt++;
      if ({imemAddr, validD, instrD, redirect} !== {r.addr, r.valid, r.instr, r.redir})
        $display("FAIL rst_pending row %0d got addr=%h v=%b instr=%h rd=%b want addr=%h v=%b instr=%h rd=%b",
                 k, imemAddr, validD, instrD, redirect, r.addr, r.valid, r.instr, r.redir);
      else passCnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_flush_stall();
    initMem();
    doReset();
    push(0,0,0,0,0,0, 32'h3000, 0, 32'h0,       0);
    push(0,0,0,0,0,0, 32'h3004, 1, w(32'h3000), 0);
    push(0,1,1,0,0,0, 32'h3008, 1, w(32'h3004), 0);
    push(0,0,0,0,1,0, 32'h3008, 0, 32'h0,       0);
    push(0,0,1,0,0,0, 32'h300C, 1, w(32'h3008), 0);
    push(0,0,0,0,0,0, 32'h3010, 0, 32'h0,       0);
    push(0,0,0,0,0,0, 32'h3014, 1, w(32'h3010), 0);
    for (int k = 0; sbQ.size() != 0; k++) begin
      row_t r = sbQ.pop_front();
      drive(r); #1;
      totalCnt++;
      if ({imemAddr, validD, instrD, redirect} !== {r.addr, r.valid, r.instr, r.redir})
        $display("FAIL flush_stall row %0d got addr=%h v=%b instr=%h rd=%b want addr=%h v=%b instr=%h rd=%b",
                 k, imemAddr, validD, instrD, redirect, r.addr, r.valid, r.instr, r.redir);
      else passCnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; isRsRtEq = 1'b0; forceJ = 1'b0; rsDataD = '0;
    test_reset();
    test_beq();
    test_jump();
    test_jr();
    test_stall();
    test_rst_pending();
    test_flush_stall();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
